// File: rtl/tnoc_fifo_write_arbiter_pkg.sv
// Shared types and helpers for the tnoc FIFO write arbiter.
// Holds the arbiter state encoding and the round-robin pointer arithmetic
// used by both the top level and the reusable selector.
package tnoc_fifo_write_arbiter_pkg;

    // Arbiter state: IDLE picks a new owner, LOCKED keeps the owner to the tail flit.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Width of a pointer/index that can address all requesters (at least one bit).
    function automatic int pointer_width(input int requesters);
        return (requesters > 1) ? $clog2(requesters) : 1;
    endfunction

    // Pointer position following 'current', wrapping back to 0 after the last requester.
    function automatic int next_pointer(input int current, input int requesters);
        if (current + 1 >= requesters) begin
            return 0;
        end
        return current + 1;
    endfunction

endpackage

// File: rtl/tnoc_round_robin_selector.sv
// Combinational round-robin selector.
// Searches i_request starting at i_pointer and moving upward with wrap; the first
// requester found gets a one-hot o_grant bit and its position on o_index.
// No request gives o_grant = 0 and o_index = 0.
module tnoc_round_robin_selector
    import tnoc_fifo_write_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int PW         = pointer_width(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [PW-1:0]         i_pointer,
    output logic [REQUESTERS-1:0] o_grant,
    output logic [PW-1:0]         o_index
);

    logic found;

    // Requester position 'offset' steps above the pointer, wrapped into range.
    function automatic logic [PW-1:0] candidate(input logic [PW-1:0] pointer, input int offset);
        int sum;
        sum = int'(pointer) + offset;
        if (sum >= REQUESTERS) begin
            sum = sum - REQUESTERS;
        end
        return PW'(sum);
    endfunction

    // Pick the first active request at or above the pointer, wrapping around.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_grant = '0;
        o_index = '0;
        found   = 1'b0;
        for (int offset = 0; offset < REQUESTERS; offset++) begin
            if (!found && i_request[candidate(i_pointer, offset)]) begin
                found                                = 1'b1;
                o_index                              = candidate(i_pointer, offset);
                o_grant[candidate(i_pointer, offset)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tnoc_fifo_write_arbiter.sv
// tnoc FIFO write arbiter.
// Shares one FIFO push port among REQUESTERS packet sources with round-robin
// arbitration and packet lock: the winner of a packet head owns the FIFO until
// its tail flit (i_last) is pushed, so packets stay contiguous in the FIFO.
// Grant is combinational (zero latency); FIFO full and i_clear gate o_ready.
// Optional build macro TNOC_FIFO_WRITE_ARBITER_ALMOST_FULL_STALL_EN: when defined,
// no new packet is started while i_fifo_almost_full is high; packets already
// in progress continue until the FIFO is actually full.
module tnoc_fifo_write_arbiter
    import tnoc_fifo_write_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic [REQUESTERS-1:0]       i_valid,
    input  logic [REQUESTERS-1:0]       i_last,
    input  logic [REQUESTERS*WIDTH-1:0] i_data,
    output logic [REQUESTERS-1:0]       o_ready,
    output logic [REQUESTERS-1:0]       o_grant,
    output logic                        o_busy,
    output logic                        o_fifo_push,
    output logic [WIDTH-1:0]            o_fifo_data,
    input  logic                        i_fifo_full,
    input  logic                        i_fifo_almost_full
);

    localparam int PW = pointer_width(REQUESTERS);

    state_t                  state;
    logic [PW-1:0]           pointer;
    logic [PW-1:0]           owner;

    logic [REQUESTERS-1:0]   sel_grant;
    logic [PW-1:0]           sel_index;
    logic [REQUESTERS-1:0]   grant;
    logic [PW-1:0]           index;
    logic [REQUESTERS-1:0]   ready;
    logic                    any_grant;
    logic                    accept;
    logic                    accept_last;
    logic                    new_packet_stall;
    logic [WIDTH-1:0]        slices [REQUESTERS];

`ifdef TNOC_FIFO_WRITE_ARBITER_ALMOST_FULL_STALL_EN
    // Hold off new packet heads while the FIFO is nearly full.
    assign new_packet_stall = i_fifo_almost_full;
`else
    logic unused_almost_full;

    // Almost-full plays no part in this build.
    assign new_packet_stall   = 1'b0;
    assign unused_almost_full = i_fifo_almost_full;
`endif

    tnoc_round_robin_selector #(
        .REQUESTERS (REQUESTERS),
        .PW         (PW)
    ) u_selector (
        .i_request (i_valid),
        .i_pointer (pointer),
        .o_grant   (sel_grant),
        .o_index   (sel_index)
    );

    // Split the flat data bus into per-source flits for the mux.
    for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
        assign slices[g] = i_data[g*WIDTH +: WIDTH];
    end

    // Current owner: the locked source, or the selector's pick when idle.
    // Held at zero while reset is asserted so all outputs drop immediately.
    always_comb begin
        grant = '0;
        index = '0;
        if (rst_n) begin
            if (state == LOCKED) begin
                grant[owner] = 1'b1;
                index        = owner;
            end else if (!new_packet_stall) begin
                grant = sel_grant;
                index = sel_index;
            end
        end
    end

    assign any_grant   = |grant;
    assign ready       = grant & {REQUESTERS{~i_fifo_full & ~i_clear}};
    assign accept      = |(i_valid & ready);
    assign accept_last = i_last[index];

    assign o_grant     = grant;
    assign o_ready     = ready;
    assign o_fifo_push = accept;
    assign o_fifo_data = any_grant ? slices[index] : '0;
    assign o_busy      = (state == LOCKED);

    // Arbitration FSM: packet lock, owner tracking and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pointer <= '0;
            owner   <= '0;
        end else if (i_clear) begin
            state   <= IDLE;
            pointer <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (accept_last) begin
                            pointer <= PW'(next_pointer(int'(index), REQUESTERS));
                        end else begin
                            state <= LOCKED;
                            owner <= index;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && accept_last) begin
                        state   <= IDLE;
                        pointer <= PW'(next_pointer(int'(owner), REQUESTERS));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
